// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: reseeds the pattern generator, runs one full LFSR period,
// drains the CUT/MISR pipeline and compares the final signature against GOLDEN.
//
// state | meaning
// IDLE  | waiting for start
// SEED  | one-cycle reseed of generator and clear of compactor
// RUN   | patterns applied, compactor capturing, pattern count advancing
// FLUSH | pipeline drain, compactor still capturing
// CHECK | signature compared against GOLDEN
// DONE  | result held until the next start
module lbist_ctrl #(
  parameter int                   BITS      = 4,
  parameter int                   SIG_BITS  = 8,
  parameter logic [SIG_BITS-1:0]  GOLDEN    = '0,
  parameter int                   FLUSH_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                rpg_end,
  input  logic [SIG_BITS-1:0] misr_sig,
  output logic                rpg_rst,
  output logic                misr_clr,
  output logic                misr_en,
  output logic                test_mode,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [BITS:0]       pat_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEED  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [BITS:0] PAT_ONE  = {{BITS{1'b0}}, 1'b1};
  localparam logic [BITS:0] PAT_MAX  = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS:0] PAT_LAST = {1'b0, {BITS{1'b1}}};
  localparam logic [3:0]    FLUSH_LOAD = (FLUSH_CYC > 0) ? 4'(FLUSH_CYC - 1) : 4'd0;

  logic [2:0] state;
  logic [3:0] flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat_count <= '0;
      flush_cnt <= '0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= SEED;
        SEED: begin
          pat_count <= '0;
          flush_cnt <= '0;
          timeout   <= 1'b0;
          pass      <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (pat_count != PAT_MAX) pat_count <= pat_count + PAT_ONE;
          // The generator sits at its seed on the first RUN cycle, so rpg_end is only
          // meaningful once at least one pattern has been applied; it beats timeout.
          if (rpg_end && (pat_count != '0)) begin
            if (FLUSH_CYC == 0) begin
              state <= CHECK;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end
          end else if (pat_count == PAT_LAST) begin
            state   <= DONE;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) state <= CHECK;
          else                   flush_cnt <= flush_cnt - 4'd1;
        end
        CHECK: begin
          pass  <= (misr_sig == GOLDEN);
          state <= DONE;
        end
        DONE: if (start) state <= SEED;
        default: state <= IDLE;
      endcase
    end
  end

  assign rpg_rst   = (state == SEED);
  assign misr_clr  = (state == SEED);
  assign test_mode = (state == RUN) || (state == FLUSH);
  assign misr_en   = (state == RUN) || (state == FLUSH);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: directed and randomized rpg_end schedules, expected run length,
// timeout and pass computed from the pattern-count rules, checked every cycle.
module tb_lbist_ctrl;
  localparam int         FLUSH_CYC = 2;
  localparam logic [7:0] GOLDEN    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rpg_end = 1'b0;
  logic [7:0] misr_sig = 8'h00;
  logic       rpg_rst, misr_clr, misr_en, test_mode, busy, done, pass, timeout;
  logic [4:0] pat_count;

  int checks = 0;
  int failures = 0;

  lbist_ctrl #(.BITS(4), .SIG_BITS(8), .GOLDEN(GOLDEN), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .rpg_end(rpg_end), .misr_sig(misr_sig),
    .rpg_rst(rpg_rst), .misr_clr(misr_clr), .misr_en(misr_en), .test_mode(test_mode),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {rpg_rst, misr_clr, misr_en, test_mode, busy, done, pass, timeout, pat_count}, 32'h0);
  endtask

  // mask[c] is rpg_end during the c-th RUN cycle (c=1 is the cycle with pat_count=0).
  task automatic run_case(input logic [31:0] mask, input logic [7:0] sig,
                          input bit keep_start, input bit toggle);
    int  len;
    bit  to;
    bit  exp_pass;
    len = 16;
    to  = 1'b1;
    for (int c = 2; c <= 16; c++) begin
      if (mask[c]) begin
        len = c;
        to  = 1'b0;
        break;
      end
    end
    exp_pass = !to && (sig == GOLDEN);
    misr_sig = sig;
    rpg_end  = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    chk("seed_pulse", {rpg_rst, misr_clr, busy, test_mode, done}, 32'b11100);
    @(negedge clk);
    for (int c = 1; c <= len; c++) begin
      rpg_end = mask[c];
      if (toggle) start = 1'($urandom);
      chk("run_mode", {test_mode, misr_en, busy, done, rpg_rst}, 32'b11100);
      chk("run_count", pat_count, c - 1);
      @(negedge clk);
    end
    rpg_end = 1'b0;
    start   = keep_start;
    if (!to) begin
      for (int f = 0; f < FLUSH_CYC; f++) begin
        chk("flush_mode", {test_mode, misr_en, busy, done}, 32'b1110);
        chk("flush_count", pat_count, len);
        @(negedge clk);
      end
      chk("check_state", {test_mode, misr_en, busy, done}, 32'b0010);
      @(negedge clk);
    end
    chk("done_flags", {done, busy, pass, timeout, misr_en, test_mode},
        {26'd0, 1'b1, 1'b0, exp_pass, to, 1'b0, 1'b0});
    chk("done_count", pat_count, len);
    @(negedge clk);
    if (keep_start) begin
      chk("restart", {rpg_rst, done, busy}, 32'b101);
      start   = 1'b0;
      rpg_end = 1'b1;
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      rpg_end = 1'b0;
      chk("restart_done", {done, timeout, pat_count}, {25'd0, 1'b1, 1'b0, 5'd2});
    end else begin
      chk("done_hold", {done, pass, timeout, pat_count}, {24'd0, 1'b1, exp_pass, to, 5'(len)});
    end
  endtask

  initial begin
    logic [31:0] mask;
    logic [7:0]  sig;
    int          first;

    #1 chk_all_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {busy, done, rpg_rst, pat_count}, 32'h0);
    end

    run_case(32'h0000_8002, 8'hA5, 1'b0, 1'b0);
    run_case(32'h0000_8002, 8'h5A, 1'b0, 1'b0);
    run_case(32'h0000_0000, 8'hA5, 1'b0, 1'b0);
    run_case(32'h0001_0000, 8'hA5, 1'b0, 1'b0);
    run_case(32'hFFFF_FFFF, 8'hA5, 1'b0, 1'b0);
    run_case(32'h0000_8002, 8'hA5, 1'b1, 1'b0);
    run_case(32'h0000_8002, 8'hA5, 1'b0, 1'b1);

    // Reset asserted mid-FLUSH must clear outputs without waiting for a clock edge.
    misr_sig = 8'hA5;
    rpg_end  = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_flush", {test_mode, misr_en, busy, pat_count}, {26'd0, 1'b1, 1'b1, 1'b1, 5'd2});
    #1 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    rpg_end = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_midrun_reset", {busy, done, pat_count}, 32'h0);
    end
    run_case(32'h0000_8002, 8'hA5, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      first = $urandom_range(2, 20);
      mask  = 32'h0;
      for (int c = first; c < 32; c++) mask[c] = 1'($urandom);
      mask[first] = 1'b1;
      mask[1] = 1'($urandom);
      sig = ($urandom_range(0, 1) == 1) ? GOLDEN : 8'($urandom);
      run_case(mask, sig, 1'b0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lbist_ctrl.md
LBIST_CTRL -- requirements
Module: lbist_ctrl

Interface
REQ-001 Parameter BITS, default 4: width of the random-pattern LFSR being sequenced.
REQ-002 Parameter SIG_BITS, default 8: width of the response signature (MISR) being checked.
REQ-003 Parameter GOLDEN, default 0 (SIG_BITS wide): expected fault-free signature.
REQ-004 Parameter FLUSH_CYC, default 2: cycles of CUT/MISR pipeline latency drained after the last pattern; legal range 0..15.
REQ-005 clk  input  1  clock; all state changes on posedge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a BIST run; level-sampled.
REQ-008 rpg_end  input  1  pattern-generator end-of-cycle flag (generator register equals seed).
REQ-009 misr_sig  input  SIG_BITS  current signature from the response compactor.
REQ-010 rpg_rst  output  1  active-high reseed pulse to the pattern generator.
REQ-011 misr_clr  output  1  synchronous clear to the compactor.
REQ-012 misr_en  output  1  compactor capture enable.
REQ-013 test_mode  output  1  selects LFSR patterns into the CUT.
REQ-014 busy  output  1  run in progress (any state except IDLE and DONE).
REQ-015 done  output  1  result valid.
REQ-016 pass  output  1  signature matched GOLDEN; meaningful only while done=1.
REQ-017 timeout  output  1  generator failed to return to seed within 2^BITS patterns.
REQ-018 pat_count  output  BITS+1  patterns applied in the last/current run.

Function
REQ-019 The FSM SHALL have states IDLE, SEED, RUN, FLUSH, CHECK, DONE, all outputs registered or pure decodes of state.
REQ-020 IDLE: start=1 -> SEED next cycle; otherwise stay.
REQ-021 SEED: exactly one cycle; rpg_rst=1, misr_clr=1, pat_count cleared to 0, flush counter cleared, timeout cleared; -> RUN.
REQ-022 RUN: test_mode=1, misr_en=1; pat_count increments by 1 every cycle.
REQ-023 RUN: rpg_end SHALL be ignored while pat_count==0 (generator sits at seed on entry).
REQ-024 RUN: rpg_end=1 with pat_count!=0 -> FLUSH; pat_count captures the incremented value of that cycle (for a 4-bit maximal LFSR, final pat_count = 15).
REQ-025 RUN: pat_count reaching 2^BITS without a qualifying rpg_end -> DONE with timeout=1, pass=0; CHECK skipped.
REQ-026 Simultaneous rpg_end and timeout condition: rpg_end wins (-> FLUSH, timeout=0).
REQ-027 FLUSH: test_mode=1, misr_en=1 for exactly FLUSH_CYC cycles, then -> CHECK; FLUSH_CYC=0 SHALL go RUN -> CHECK directly.
REQ-028 CHECK: one cycle, misr_en=0, test_mode=0; pass registered as (misr_sig == GOLDEN); -> DONE.
REQ-029 DONE: done=1; pass, timeout, pat_count held stable.
REQ-030 DONE: start=1 -> SEED (restart, done drops the next cycle); start=0 -> stay.
REQ-031 start while busy=1 SHALL be ignored; no abort input exists.
REQ-032 pat_count SHALL saturate at 2^BITS and never wrap.
REQ-033 rpg_rst, misr_clr are single-cycle pulses, asserted only in SEED.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE and all outputs to 0 (rpg_rst, misr_clr, misr_en, test_mode, busy, done, pass, timeout, pat_count), including mid-run.
REQ-035 After rst deassertion the block SHALL remain in IDLE until start=1 is sampled.

Verification (BITS=4, SIG_BITS=8, FLUSH_CYC=2, GOLDEN=8'hA5)
REQ-036 Nominal: start pulse, rpg_end modelled at period 15, misr_sig=8'hA5 in CHECK -> SEED 1 cycle, RUN 15 cycles, FLUSH 2, CHECK 1, done=1, pass=1, pat_count=15.
REQ-037 Bad signature: same stimulus, misr_sig=8'h5A -> done=1, pass=0, timeout=0.
REQ-038 Stuck generator: rpg_end never rises -> after pat_count=16, done=1, timeout=1, pass=0, misr_en=0 from that cycle.
REQ-039 rpg_end held high from run start -> not accepted at pat_count=0; FLUSH entered when pat_count=1.
REQ-040 rst=0 asserted in FLUSH -> all outputs 0 immediately (before next clk edge); FSM IDLE; start after release reruns cleanly.
REQ-041 start held high throughout -> run completes, one DONE cycle, then SEED again; start toggled during RUN has no effect.
